// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register {pc, instruction, meta} with a 2-entry skid buffer, flush and single-step gating.
// Optional stalled-cycle counter is built when STALL_CNT_EN is defined; otherwise o_stall_cnt is tied to 0.
module pipe_stage_reg #(
    parameter int NBITS     = 32,
    parameter int META_BITS = 8,
    parameter int CNT_BITS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_step,
    input  logic                 i_flush,
    input  logic                 i_stall,
    input  logic                 i_valid,
    input  logic [NBITS-1:0]     i_pc,
    input  logic [NBITS-1:0]     i_instruction,
    input  logic [META_BITS-1:0] i_meta,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [NBITS-1:0]     o_pc,
    output logic [NBITS-1:0]     o_instruction,
    output logic [META_BITS-1:0] o_meta,
    output logic [CNT_BITS-1:0]  o_stall_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]           r_state;
    logic [NBITS-1:0]     r_pc;
    logic [NBITS-1:0]     r_instr;
    logic [META_BITS-1:0] r_meta;
    logic [NBITS-1:0]     r_skid_pc;
    logic [NBITS-1:0]     r_skid_instr;
    logic [META_BITS-1:0] r_skid_meta;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Handshake: a word moves upstream->stage when i_valid & o_ready, and
    // stage->downstream when o_valid & ~i_stall, in both cases only on a stepped cycle.
    // o_ready depends on the state register alone, so no combinational path from i_stall/i_valid.
    assign w_ready = (r_state != S_TWO);
    assign w_valid = (r_state != S_EMPTY);
    assign w_push  = i_step & i_valid & w_ready;
    assign w_pop   = i_step & w_valid & ~i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_EMPTY;
            r_pc         <= '0;
            r_instr      <= '0;
            r_meta       <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_meta  <= '0;
        end else if (i_step) begin
            if (i_flush) begin
                r_state      <= S_EMPTY;
                r_pc         <= '0;
                r_instr      <= '0;
                r_meta       <= '0;
                r_skid_pc    <= '0;
                r_skid_instr <= '0;
                r_skid_meta  <= '0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_push) begin
                            r_pc    <= i_pc;
                            r_instr <= i_instruction;
                            r_meta  <= i_meta;
                            r_state <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_push && w_pop) begin
                            r_pc    <= i_pc;
                            r_instr <= i_instruction;
                            r_meta  <= i_meta;
                        end else if (w_push) begin
                            r_skid_pc    <= i_pc;
                            r_skid_instr <= i_instruction;
                            r_skid_meta  <= i_meta;
                            r_state      <= S_TWO;
                        end else if (w_pop) begin
                            // Emptied main reads as a NOP bubble.
                            r_pc    <= '0;
                            r_instr <= '0;
                            r_meta  <= '0;
                            r_state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (w_pop) begin
                            r_pc    <= r_skid_pc;
                            r_instr <= r_skid_instr;
                            r_meta  <= r_skid_meta;
                            r_state <= S_ONE;
                        end
                    end
                    default: begin
                        r_pc    <= '0;
                        r_instr <= '0;
                        r_meta  <= '0;
                        r_state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o_ready       = w_ready;
    assign o_valid       = w_valid;
    assign o_pc          = r_pc;
    assign o_instruction = r_instr;
    assign o_meta        = r_meta;

`ifdef STALL_CNT_EN
    logic [CNT_BITS-1:0] r_stall_cnt;

    // Saturating; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_step && w_valid && i_stall && !i_flush && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule
